// File: rtl/genesis_pad_emulator_pkg.sv
// ---------------------------------------------------------------------------
// genesis_pad_emulator_pkg
// Shared definitions for the Genesis pad emulator:
//   - phase_e   : output phase encodings (P_HIGH..P_ONES)
//   - BTN_*     : bit indices into the 12-bit active-high button vector
//                 {Z,Y,X,M,S,C,B,A,U,D,L,R}, same order as the gamepad reader
//   - select_phase() : phase to present after a TH edge
//   - pad_drive()    : active-low 6-bit pad word for a phase and button set
// ---------------------------------------------------------------------------
package genesis_pad_emulator_pkg;

  typedef enum logic [2:0] {
    P_HIGH = 3'd0,
    P_LOW  = 3'd1,
    P_ZERO = 3'd2,
    P_XYZM = 3'd3,
    P_ONES = 3'd4
  } phase_e;

  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_A = 4;
  localparam int BTN_B = 5;
  localparam int BTN_C = 6;
  localparam int BTN_S = 7;
  localparam int BTN_M = 8;
  localparam int BTN_X = 9;
  localparam int BTN_Y = 10;
  localparam int BTN_Z = 11;

  // Saturation points of the falling-edge counter.
  localparam logic [2:0] K_SAT_SIX   = 3'd5;
  localparam logic [2:0] K_SAT_THREE = 3'd1;

  // th_level is the synced TH level after the edge, k the updated edge count.
  function automatic phase_e select_phase(input logic       th_level,
                                          input logic [2:0] k,
                                          input logic       six);
    phase_e ph;
    ph = P_HIGH;
    if (th_level) begin
      ph = (six && k == 3'd3) ? P_XYZM : P_HIGH;
    end else if (!six) begin
      ph = P_LOW;
    end else begin
      case (k)
        3'd3:    ph = P_ZERO;
        3'd4:    ph = P_ONES;
        default: ph = P_LOW;
      endcase
    end
    return ph;
  endfunction

  // Pad word order {C/Start, B/A, Up/Z, Down/Y, Left/X, Right/Mode}, active low.
  function automatic logic [5:0] pad_drive(input phase_e      ph,
                                           input logic [11:0] btn);
    logic [5:0] d;
    d = 6'b111111;
    case (ph)
      P_HIGH: d = ~{btn[BTN_C], btn[BTN_B], btn[BTN_U],
                    btn[BTN_D], btn[BTN_L], btn[BTN_R]};
      P_XYZM: d = ~{btn[BTN_C], btn[BTN_B], btn[BTN_Z],
                    btn[BTN_Y], btn[BTN_X], btn[BTN_M]};
      P_LOW:  d = {~btn[BTN_S], ~btn[BTN_A], ~btn[BTN_U], ~btn[BTN_D], 2'b00};
      P_ZERO: d = {~btn[BTN_S], ~btn[BTN_A], 4'b0000};
      P_ONES: d = {~btn[BTN_S], ~btn[BTN_A], 4'b1111};
      default: d = 6'b111111;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/genesis_pad_sync.sv
// ---------------------------------------------------------------------------
// genesis_pad_sync
// Brings the console TH line into the clock domain and detects its edges.
// Ports:
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset (all flops reset to 1 = TH idle high)
//   select_i : raw TH line, asynchronous
//   level_o  : synchronized TH level
//   rise_o   : one-cycle pulse on a synced rising edge
//   fall_o   : one-cycle pulse on a synced falling edge
// ---------------------------------------------------------------------------
module genesis_pad_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic select_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= select_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/genesis_pad_emulator.sv
// ---------------------------------------------------------------------------
// genesis_pad_emulator
// Device-side emulation of a Genesis 3/6-button pad. Tracks console TH edges,
// runs the 6-button phase sequence with an inactivity timeout and drives the
// six active-low data lines.
// Parameters:
//   TIMEOUT_TICKS  : idle cycles without a TH edge before the edge count clears
//   RESPONSE_DELAY : extra cycles between a detected edge and the phase switch
// Ports:
//   iCLK        : system clock
//   iN_RESET    : asynchronous active-low reset
//   iSELECT     : TH line from the console (asynchronous)
//   iBUTTONS    : active-high {Z,Y,X,M,S,C,B,A,U,D,L,R}
//   iSIX_BUTTON : 1 = 6-button pad, 0 = 3-button pad
//   oGENPAD     : active-low {C/Start,B/A,Up/Z,Down/Y,Left/X,Right/Mode}
//   oPHASE      : phase currently presented
//   oACTIVE     : high while the idle counter is below TIMEOUT_TICKS
// ---------------------------------------------------------------------------
module genesis_pad_emulator
  import genesis_pad_emulator_pkg::*;
#(
  parameter int TIMEOUT_TICKS  = 75000,
  parameter int RESPONSE_DELAY = 4
) (
  input  logic        iCLK,
  input  logic        iN_RESET,
  input  logic        iSELECT,
  input  logic [11:0] iBUTTONS,
  input  logic        iSIX_BUTTON,
  output logic [5:0]  oGENPAD,
  output logic [2:0]  oPHASE,
  output logic        oACTIVE
);

  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int DLY_W = ($clog2(RESPONSE_DELAY + 1) < 1) ? 1 : $clog2(RESPONSE_DELAY + 1);

  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_TICKS);
  localparam logic [TO_W-1:0]  TO_HIT   = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(RESPONSE_DELAY);

  logic th_level;
  logic th_rise;
  logic th_fall;

  genesis_pad_sync u_sync (
    .clk_i    (iCLK),
    .rst_ni   (iN_RESET),
    .select_i (iSELECT),
    .level_o  (th_level),
    .rise_o   (th_rise),
    .fall_o   (th_fall)
  );

  logic [2:0]       k_q, k_d;
  logic             six_q, six_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic             pend_valid_q, pend_valid_d;
  phase_e           pend_phase_q, pend_phase_d;
  phase_e           act_phase_q, act_phase_d;
  logic [5:0]       genpad_q, genpad_d;

  logic       timeout_hit;
  logic [2:0] k_base;
  logic [2:0] k_sat;
  logic       edge_seen;
  phase_e     edge_phase;

  always_comb begin
    // The counter reaches TIMEOUT_TICKS at the end of this cycle (or already
    // sits there): k is cleared before any edge in the same cycle is counted.
    timeout_hit  = (to_cnt_q >= TO_HIT);
    k_base       = timeout_hit ? 3'd0 : k_q;
    k_d          = k_base;
    six_d        = six_q;
    k_sat        = K_SAT_SIX;
    edge_seen    = th_rise | th_fall;

    if (th_fall) begin
      six_d = iSIX_BUTTON;
      k_sat = iSIX_BUTTON ? K_SAT_SIX : K_SAT_THREE;
      k_d   = (k_base >= k_sat) ? k_sat : k_base + 3'd1;
    end

    // Rising edges reuse the mode captured on the last falling edge.
    edge_phase = select_phase(th_level, k_d, six_d);

    to_cnt_d = to_cnt_q;
    if (edge_seen) begin
      to_cnt_d = '0;
    end else if (to_cnt_q < TO_MAX) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    // Newest edge always wins: it overwrites the pending phase and restarts
    // the delay, so an intermediate phase is never shown.
    pend_phase_d = pend_phase_q;
    pend_valid_d = pend_valid_q;
    dly_cnt_d    = dly_cnt_q;
    act_phase_d  = act_phase_q;
    if (edge_seen) begin
      pend_phase_d = edge_phase;
      pend_valid_d = 1'b1;
      dly_cnt_d    = DLY_LOAD;
    end else if (pend_valid_q) begin
      if (dly_cnt_q == '0) begin
        act_phase_d  = pend_phase_q;
        pend_valid_d = 1'b0;
      end else begin
        dly_cnt_d = dly_cnt_q - 1'b1;
      end
    end

    genpad_d = pad_drive(act_phase_q, iBUTTONS);
  end

  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET) begin
      k_q          <= 3'd0;
      six_q        <= 1'b0;
      to_cnt_q     <= TO_MAX;
      dly_cnt_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_phase_q <= P_HIGH;
      act_phase_q  <= P_HIGH;
      genpad_q     <= 6'b111111;
    end else begin
      k_q          <= k_d;
      six_q        <= six_d;
      to_cnt_q     <= to_cnt_d;
      dly_cnt_q    <= dly_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_phase_q <= pend_phase_d;
      act_phase_q  <= act_phase_d;
      genpad_q     <= genpad_d;
    end
  end

  assign oGENPAD = genpad_q;
  assign oPHASE  = act_phase_q;
  assign oACTIVE = (to_cnt_q < TO_MAX);

endmodule

// File: tb/tb_genesis_pad_emulator.sv
// ---------------------------------------------------------------------------
// tb_genesis_pad_emulator
// Directed bench for genesis_pad_emulator with a short timeout so that
// inactivity behaviour can be reached quickly. TH changes are driven 1 ns
// after a rising clock edge; outputs are sampled 1 ns after later edges.
// ---------------------------------------------------------------------------
module tb_genesis_pad_emulator;

  localparam int T = 300;  // TIMEOUT_TICKS used here
  localparam int H = 20;   // TH half-period in clock cycles

  logic        iCLK = 1'b0;
  logic        iN_RESET;
  logic        iSELECT;
  logic [11:0] iBUTTONS;
  logic        iSIX_BUTTON;
  logic [5:0]  oGENPAD;
  logic [2:0]  oPHASE;
  logic        oACTIVE;

  int checks = 0;
  int errors = 0;

  genesis_pad_emulator #(
    .TIMEOUT_TICKS  (T),
    .RESPONSE_DELAY (4)
  ) dut (
    .iCLK        (iCLK),
    .iN_RESET    (iN_RESET),
    .iSELECT     (iSELECT),
    .iBUTTONS    (iBUTTONS),
    .iSIX_BUTTON (iSIX_BUTTON),
    .oGENPAD     (oGENPAD),
    .oPHASE      (oPHASE),
    .oACTIVE     (oACTIVE)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one TH half-period: output is checked 9 cycles after the change.
  task automatic half(input string tag, input logic lvl,
                      input logic [5:0] epad, input logic [2:0] eph);
    iSELECT = lvl;
    tick(9);
    check({tag, "_pad"}, {26'd0, oGENPAD}, {26'd0, epad});
    check({tag, "_ph"},  {29'd0, oPHASE},  {29'd0, eph});
    $display("step %s sel=%0b pad=%b phase=%0d", tag, lvl, oGENPAD, oPHASE);
    tick(H - 9);
  endtask

  initial begin
    // ---- reset state ----
    iN_RESET    = 1'b0;
    iSELECT     = 1'b1;
    iBUTTONS    = 12'h000;
    iSIX_BUTTON = 1'b1;
    #23;
    check("rst_pad", {26'd0, oGENPAD}, 32'h3F);
    check("rst_ph", {29'd0, oPHASE}, 32'd0);
    check("rst_active", {31'd0, oACTIVE}, 32'd0);
    @(posedge iCLK); #1;
    iN_RESET = 1'b1;
    tick(3);
    check("post_rst_pad", {26'd0, oGENPAD}, 32'h3F);
    check("post_rst_active", {31'd0, oACTIVE}, 32'd0);

    // ---- S+A pressed, single low: 9-cycle latency ----
    iBUTTONS = 12'h090;
    iSELECT  = 1'b0;
    tick(8);
    check("lat8_pad", {26'd0, oGENPAD}, 32'h3F);
    tick(1);
    check("lat9_pad", {26'd0, oGENPAD}, 32'b001100);
    check("lat9_ph", {29'd0, oPHASE}, 32'd1);
    check("lat9_active", {31'd0, oACTIVE}, 32'd1);
    $display("step lat sel=0 pad=%b phase=%0d", oGENPAD, oPHASE);
    tick(11);

    // ---- back high, then let the idle counter run out ----
    iSELECT = 1'b1;
    tick(9);
    check("sa_high_pad", {26'd0, oGENPAD}, 32'h3F);
    tick(T - 7);
    check("active_before_to", {31'd0, oACTIVE}, 32'd1);
    tick(1);
    check("active_after_to", {31'd0, oACTIVE}, 32'd0);
    $display("step timeout active=%0b", oACTIVE);

    // ---- button change shows one cycle later without phase change ----
    iBUTTONS = 12'h040;
    tick(1);
    check("btn_c_pad", {26'd0, oGENPAD}, 32'b011111);
    check("btn_c_ph", {29'd0, oPHASE}, 32'd0);
    iBUTTONS = 12'h900;
    tick(1);
    check("btn_zm_pad", {26'd0, oGENPAD}, 32'h3F);

    // ---- six-button sequence, Z and M held ----
    half("six_l1", 1'b0, 6'b111100, 3'd1);
    half("six_h1", 1'b1, 6'b111111, 3'd0);
    half("six_l2", 1'b0, 6'b111100, 3'd1);
    half("six_h2", 1'b1, 6'b111111, 3'd0);
    half("six_l3", 1'b0, 6'b110000, 3'd2);
    half("six_h3", 1'b1, 6'b110110, 3'd3);
    half("six_l4", 1'b0, 6'b111111, 3'd4);
    half("six_h4", 1'b1, 6'b111111, 3'd0);
    half("six_l5", 1'b0, 6'b111100, 3'd1);
    half("six_h5", 1'b1, 6'b111111, 3'd0);
    half("six_l6", 1'b0, 6'b111100, 3'd1);
    half("six_h6", 1'b1, 6'b111111, 3'd0);
    tick(T + 10);

    // ---- three-button mode, same stimulus ----
    iSIX_BUTTON = 1'b0;
    half("three_l1", 1'b0, 6'b111100, 3'd1);
    half("three_h1", 1'b1, 6'b111111, 3'd0);
    half("three_l2", 1'b0, 6'b111100, 3'd1);
    half("three_h2", 1'b1, 6'b111111, 3'd0);
    half("three_l3", 1'b0, 6'b111100, 3'd1);
    half("three_h3", 1'b1, 6'b111111, 3'd0);
    half("three_l4", 1'b0, 6'b111100, 3'd1);
    half("three_h4", 1'b1, 6'b111111, 3'd0);
    iSIX_BUTTON = 1'b1;
    tick(T + 10);

    // ---- timeout mid-sequence (k=2) restarts the count ----
    half("to_l1", 1'b0, 6'b111100, 3'd1);
    half("to_h1", 1'b1, 6'b111111, 3'd0);
    half("to_l2", 1'b0, 6'b111100, 3'd1);
    half("to_h2", 1'b1, 6'b111111, 3'd0);
    tick(T + 10);
    check("to_idle_active", {31'd0, oACTIVE}, 32'd0);
    half("res_l1", 1'b0, 6'b111100, 3'd1);
    check("res_active", {31'd0, oACTIVE}, 32'd1);
    half("res_h1", 1'b1, 6'b111111, 3'd0);
    half("res_l2", 1'b0, 6'b111100, 3'd1);
    half("res_h2", 1'b1, 6'b111111, 3'd0);
    half("res_l3", 1'b0, 6'b110000, 3'd2);
    half("res_h3", 1'b1, 6'b110110, 3'd3);
    tick(T + 10);

    // ---- falling edge exactly on the timeout cycle counts as k=1 ----
    half("ex_l1", 1'b0, 6'b111100, 3'd1);
    half("ex_h1", 1'b1, 6'b111111, 3'd0);
    half("ex_l2", 1'b0, 6'b111100, 3'd1);
    half("ex_h2", 1'b1, 6'b111111, 3'd0);
    tick(T - H);
    half("ex_edge_l", 1'b0, 6'b111100, 3'd1);
    half("ex_h3", 1'b1, 6'b111111, 3'd0);
    half("ex_l4", 1'b0, 6'b111100, 3'd1);
    half("ex_h4", 1'b1, 6'b111111, 3'd0);
    half("ex_l5", 1'b0, 6'b110000, 3'd2);
    half("ex_h5", 1'b1, 6'b110110, 3'd3);
    tick(T + 10);

    // ---- one cycle earlier the count survives: third low is P_ZERO ----
    half("early_l1", 1'b0, 6'b111100, 3'd1);
    half("early_h1", 1'b1, 6'b111111, 3'd0);
    half("early_l2", 1'b0, 6'b111100, 3'd1);
    half("early_h2", 1'b1, 6'b111111, 3'd0);
    tick(T - H - 1);
    half("early_edge_l", 1'b0, 6'b110000, 3'd2);
    half("early_h3", 1'b1, 6'b110110, 3'd3);
    tick(T + 10);

    // ---- asynchronous reset at k=3 with TH low ----
    half("ar_l1", 1'b0, 6'b111100, 3'd1);
    half("ar_h1", 1'b1, 6'b111111, 3'd0);
    half("ar_l2", 1'b0, 6'b111100, 3'd1);
    half("ar_h2", 1'b1, 6'b111111, 3'd0);
    half("ar_l3", 1'b0, 6'b110000, 3'd2);
    #3;
    iN_RESET = 1'b0;
    #1;
    check("arst_pad", {26'd0, oGENPAD}, 32'h3F);
    check("arst_ph", {29'd0, oPHASE}, 32'd0);
    check("arst_active", {31'd0, oACTIVE}, 32'd0);
    $display("step async_reset pad=%b phase=%0d", oGENPAD, oPHASE);
    iSELECT = 1'b1;
    @(posedge iCLK); #1;
    iN_RESET = 1'b1;
    tick(3);
    check("arst_rel_pad", {26'd0, oGENPAD}, 32'h3F);
    half("pr_l1", 1'b0, 6'b111100, 3'd1);
    half("pr_h1", 1'b1, 6'b111111, 3'd0);
    half("pr_l2", 1'b0, 6'b111100, 3'd1);
    half("pr_h2", 1'b1, 6'b111111, 3'd0);
    half("pr_l3", 1'b0, 6'b110000, 3'd2);
    half("pr_h3", 1'b1, 6'b110110, 3'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
